vga_wb_vmem_slave: RTL
======================

VGA_WB_VMEM_SLAVE -- requirements
Module: vga_wb_vmem_slave

Interface
REQ-001 SHALL have parameter AWIDTH, default 10, giving the word-address width (memory depth 2^AWIDTH x 32 bits).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, giving the byte base address of the window; bits [AWIDTH+1:0] are ignored.
REQ-003 SHALL have wb_clk_i  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have rst_nreset_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have wb_rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have wb_adr_i  input  30  word address [31:2].
REQ-007 SHALL have wb_dat_i  input  32  write data.
REQ-008 SHALL have wb_dat_o  output  32  read data.
REQ-009 SHALL have wb_sel_i  input  4  byte selects.
REQ-010 SHALL have wb_we_i, wb_stb_i, wb_cyc_i, wb_cab_i  input  1 each  write enable, strobe, cycle, continuous address burst.
REQ-011 SHALL have wb_ack_o, wb_err_o  output  1 each  acknowledge, error.

Function
REQ-012 SHALL decode a hit when wb_adr_i[31:AWIDTH+2] equals BASE[31:AWIDTH+2]; request = wb_cyc_i & wb_stb_i.
REQ-013 SHALL use one synchronous single-port RAM with a one-cycle registered read and byte-lane write enables.
REQ-014 SHALL implement FSM states IDLE, RD_WAIT, RD_STREAM, WR_ACK, ERR.
REQ-015 IDLE: request with miss -> ERR; request with hit and write -> WR_ACK; request with hit and read -> RD_WAIT (RAM read issued at wb_adr_i).
REQ-016 ERR SHALL assert wb_err_o for exactly one cycle, perform no RAM write, then return to IDLE; wb_ack_o SHALL be low.
REQ-017 WR_ACK SHALL assert wb_ack_o for one cycle and write only the lanes with wb_sel_i set, on that same edge; sel=0000 acks with no write; then return to IDLE.
REQ-018 Single read latency: stb sampled in cycle N, wb_ack_o high with valid wb_dat_o in cycle N+2 (one cycle in RD_WAIT, one cycle with ack), then IDLE.
REQ-019 Burst read (wb_cab_i high at request): while acking address A, the block SHALL prefetch A+1 (wrapping modulo 2^AWIDTH) and enter RD_STREAM, acking every following cycle for as long as the presented address equals the prefetched one.
REQ-020 RD_STREAM address mismatch SHALL deassert ack for one cycle, re-read at the presented address, and resume acking (one wait state).
REQ-021 A burst SHALL end, returning to IDLE without ack, when wb_cyc_i, wb_stb_i or wb_cab_i drops, or when a write or a miss is presented.
REQ-022 Reads SHALL ignore wb_sel_i and always return all 32 bits.
REQ-023 wb_ack_o and wb_err_o SHALL be registered and never both high; nothing is acked when wb_cyc_i is low.
REQ-024 wb_dat_o SHALL hold the last read value when wb_ack_o is low.
REQ-025 Single accesses with wb_cab_i low SHALL each return through IDLE (ack rate of at most one per two cycles).

Reset
REQ-026 rst_nreset_i low SHALL immediately force state IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0 and the prefetch address to 0; RAM contents are not cleared.
REQ-027 wb_rst_i high SHALL produce the same result on the next edge and override any other transition.
REQ-028 Reset during a burst SHALL abort it without a further ack; no write is performed on the reset edge.

Structure
REQ-029 FSM state encodings and the window-decode helper SHALL live in the shared vga package; AWIDTH and BASE stay module parameters.
REQ-030 The RAM SHALL be one sub-module, vga_vmem_spram (parameterised depth, 4 byte lanes), inferable as Altera and Xilinx block RAM.

Verification
REQ-031 Write 32'hDEADBEEF, sel 1111, to BASE+0x10 -> ack one cycle after stb; read back -> ack at N+2, data DEADBEEF.
REQ-032 Write 32'h000000AA with sel 0001 over DEADBEEF -> read returns DEADBEAA.
REQ-033 Burst read, cab=1, of 8 incrementing words from word 2^AWIDTH-4 -> acks on 8 consecutive cycles after the first (N+2) and the address wraps to word 0 with correct data.
REQ-034 Burst with address jump (3 -> 7) -> exactly one ack-less cycle, then data of word 7.
REQ-035 Access to BASE + 2^(AWIDTH+2) -> wb_err_o for one cycle, no ack, memory unchanged.
REQ-036 Assert rst_nreset_i low mid-burst -> ack/err low immediately; the next single read completes normally with latency 2.

Source files
------------

// File: rtl/vga_wb_vmem_slave_pkg.sv
// Shared definitions for the VGA video-memory Wishbone slave: FSM encoding
// and the address-window decode helper.
package vga_wb_vmem_slave_pkg;

    localparam int unsigned NUM_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_WAIT   = 3'd1,
        ST_RD_STREAM = 3'd2,
        ST_WR_ACK    = 3'd3,
        ST_ERR       = 3'd4
    } vmem_state_t;

    // True when word address adr falls in the 2^awidth-word window at byte address base.
    function automatic logic win_hit(input logic [29:0] adr,
                                     input logic [31:0] base,
                                     input int unsigned awidth);
        logic [29:0] base_w;
        base_w = base[31:2];
        return (adr >> awidth) == (base_w >> awidth);
    endfunction

endpackage

// File: rtl/vga_wb_vmem_slave_spram.sv
// Single-port 32-bit RAM with four byte-lane write enables and a registered
// read port (read-before-write), written so FPGA tools map it to block RAM.
module vga_vmem_spram #(
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk,
    input  logic [AWIDTH-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       din,
    output logic [31:0]       dout
);

    logic [31:0] mem [0:(1<<AWIDTH)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= din[i*8 +: 8];
            end
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/vga_wb_vmem_slave.sv
// Wishbone slave exposing a 2^AWIDTH x 32 video memory window at BASE, with
// registered ack/err and full-rate incrementing (cab) read bursts.
module vga_wb_vmem_slave
    import vga_wb_vmem_slave_pkg::*;
#(
    parameter int unsigned AWIDTH = 10,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        wb_clk_i,
    input  logic        rst_nreset_i,
    input  logic        wb_rst_i,
    input  logic [29:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_cab_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    // Handshake: a beat is requested while cyc & stb are high and completes in
    // the cycle ack (or err) is high; inside a cab burst the master presents
    // its next address in that same ack cycle, which is what gets compared
    // against the prefetch address.
    vmem_state_t       state;
    logic [AWIDTH-1:0] pf_addr;
    logic [AWIDTH-1:0] adr_w;
    logic [AWIDTH-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_q;
    logic              burst;
    logic              req;
    logic              hit;
    logic              pf_match;
    logic              stream_ok;

    assign adr_w     = wb_adr_i[AWIDTH-1:0];
    assign req       = wb_cyc_i & wb_stb_i;
    assign hit       = win_hit(wb_adr_i, BASE, AWIDTH);
    assign pf_match  = (adr_w == pf_addr);
    assign stream_ok = req & wb_cab_i & ~wb_we_i & hit;

    // Writes land on the edge that raises ack; any reset on that edge blocks them.
    assign ram_we = (state == ST_IDLE && req && hit && wb_we_i && rst_nreset_i && !wb_rst_i)
                    ? wb_sel_i : 4'b0000;

    always_comb begin
        ram_addr = adr_w;
        case (state)
            ST_RD_WAIT:   ram_addr = pf_addr;
            ST_RD_STREAM: if (pf_match) ram_addr = pf_addr + 1'b1;
            default:      ram_addr = adr_w;
        endcase
    end

    vga_vmem_spram #(.AWIDTH(AWIDTH)) u_ram (
        .clk  (wb_clk_i),
        .addr (ram_addr),
        .we   (ram_we),
        .din  (wb_dat_i),
        .dout (ram_q)
    );

    always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            state    <= ST_IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            pf_addr  <= '0;
            burst    <= 1'b0;
        end else if (wb_rst_i) begin
            state    <= ST_IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            pf_addr  <= '0;
            burst    <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (!hit) begin
                            state    <= ST_ERR;
                            wb_err_o <= 1'b1;
                        end else if (wb_we_i) begin
                            state    <= ST_WR_ACK;
                            wb_ack_o <= 1'b1;
                        end else begin
                            state   <= ST_RD_WAIT;
                            pf_addr <= adr_w + 1'b1;
                            burst   <= wb_cab_i;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (req) begin
                        wb_ack_o <= 1'b1;
                        wb_dat_o <= ram_q;
                        state    <= (burst && stream_ok) ? ST_RD_STREAM : ST_IDLE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD_STREAM: begin
                    if (!stream_ok) begin
                        state <= ST_IDLE;
                    end else if (pf_match) begin
                        wb_ack_o <= 1'b1;
                        wb_dat_o <= ram_q;
                        pf_addr  <= pf_addr + 1'b1;
                    end else begin
                        // Address jump: this cycle re-reads, the next one acks.
                        pf_addr <= adr_w;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
